// File: rtl/pdm_window_counter_pkg.sv
// Shared constants and FSM encoding for the PDM sliding-window ones counter.
package pdm_window_counter_pkg;

    localparam int CNTR_WIDTH  = 10;
    localparam int WIN_LEN_DEF = 1000;
    localparam int CLK_DIV_DEF = 25;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pdm_window_counter_clk_gen.sv
// Microphone clock divider. mic_clk toggles every CLK_DIV clk cycles.
// The sample strobe is asserted in the cycle whose clock edge takes
// mic_clk from 0 to 1.
module pdm_clk_gen
    import pdm_window_counter_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic mic_clk,
    output logic strobe
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] div_cnt;
    logic        div_hit;

    assign div_hit = (div_cnt == DIV_LAST);
    assign strobe  = div_hit && !mic_clk;

    // Half-period counter; toggles mic_clk on each terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else if (div_hit) begin
            div_cnt <= '0;
            mic_clk <= ~mic_clk;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/pdm_window_counter.sv
// Counts the ones among the last WIN_LEN PDM samples using a ring buffer
// and a running sum. The sample strobe is the sample_en port by default.
// Define PDM_CLK_GEN_EN to generate mic_clk internally instead; the strobe
// then fires on each rising edge of mic_clk.
module pdm_window_counter
    import pdm_window_counter_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pdm_data,
`ifdef PDM_CLK_GEN_EN
    output logic                  mic_clk,
`else
    input  logic                  sample_en,
`endif
    output logic [CNTR_WIDTH-1:0] cntr,
    output logic                  cntr_valid
);

    localparam logic [CNTR_WIDTH-1:0] LAST_IDX = CNTR_WIDTH'(WIN_LEN - 1);

    if (WIN_LEN < 2 || WIN_LEN > 1023 || CLK_DIV < 1) begin : g_bad_param
        $error("pdm_window_counter: WIN_LEN must be 2..1023 and CLK_DIV >= 1");
    end

    logic strobe;

`ifdef PDM_CLK_GEN_EN
    pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .mic_clk (mic_clk),
        .strobe  (strobe)
    );
`else
    assign strobe = sample_en;
`endif

    logic [WIN_LEN-1:0]    ring;
    logic [CNTR_WIDTH-1:0] wr_ptr;
    logic [CNTR_WIDTH-1:0] fill_cnt;
    logic [CNTR_WIDTH-1:0] count;
    logic [CNTR_WIDTH-1:0] count_nxt;
    state_t                state_q, state_d;
    logic                  old_bit;
    logic                  emit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Leave FILL on the strobe that stores the WIN_LEN-th sample.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (strobe && fill_cnt == LAST_IDX) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = FILL;
        endcase
    end

    // During FILL the ring holds stale data from before reset, so the
    // evicted bit is forced to 0.
    always_comb begin
        old_bit = 1'b0;
        emit    = 1'b0;
        if (state_q == RUN) begin
            old_bit = ring[wr_ptr];
            emit    = strobe;
        end else begin
            emit    = strobe && (fill_cnt == LAST_IDX);
        end
    end

    // The running sum stays within 0..WIN_LEN: a bit is only subtracted
    // after it has been added to the sum.
    assign count_nxt = count + CNTR_WIDTH'(pdm_data) - CNTR_WIDTH'(old_bit);

    // Ring storage is not reset. FILL masks any stale contents.
    always_ff @(posedge clk) begin
        if (strobe) ring[wr_ptr] <= pdm_data;
    end

    // Pointer, fill progress, running sum and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            count      <= '0;
            cntr       <= '0;
            cntr_valid <= 1'b0;
        end else begin
            cntr_valid <= emit;
            if (strobe) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                count  <= count_nxt;
                if (state_q == FILL) fill_cnt <= fill_cnt + 1'b1;
            end
            if (emit) cntr <= count_nxt;
        end
    end

endmodule

// File: tb/tb_pdm_window_counter.sv
// Randomized self-checking bench for pdm_window_counter (WIN_LEN = 1000).
// With PDM_CLK_GEN_EN defined, the DUT is built with CLK_DIV = 4, and the
// bench predicts the strobe timing from the mic clock period.
module tb_pdm_window_counter;

    localparam int WIN_LEN = 1000;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pdm_data = 1'b0;
    logic       sample_en = 1'b0;
    logic       mic_clk;
    logic [9:0] cntr;
    logic       cntr_valid;

    int errors = 0;
    int checks = 0;

    // Reference model: the most recent WIN_LEN samples and the number of
    // samples seen since reset.
    bit hist[$];
    int nseen     = 0;
    int exp_cntr  = 0;
    bit exp_valid = 1'b0;
    int k         = 0;
    bit exp_mic   = 1'b0;

    pdm_window_counter #(.WIN_LEN(WIN_LEN), .CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .pdm_data   (pdm_data),
`ifdef PDM_CLK_GEN_EN
        .mic_clk    (mic_clk),
`else
        .sample_en  (sample_en),
`endif
        .cntr       (cntr),
        .cntr_valid (cntr_valid)
    );

`ifndef PDM_CLK_GEN_EN
    assign mic_clk = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int window_sum();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    task automatic check_outputs();
        chk("cntr_valid", cntr_valid, exp_valid);
        chk("cntr", cntr, exp_cntr);
`ifdef PDM_CLK_GEN_EN
        chk("mic_clk", mic_clk, exp_mic);
`endif
    endtask

    // One clk cycle: check the previous edge, then drive the next edge.
    task automatic step(input bit en, input bit d, output bit fired);
        @(negedge clk);
        check_outputs();
`ifdef PDM_CLK_GEN_EN
        k++;
        fired   = (k % (2 * CLK_DIV)) == CLK_DIV;
        exp_mic = ((k / CLK_DIV) % 2) == 1;
        if (en) fired = fired;
`else
        fired     = en;
        sample_en = en;
`endif
        pdm_data  = d;
        exp_valid = 1'b0;
        if (fired) begin
            hist.push_back(d);
            if (hist.size() > WIN_LEN) void'(hist.pop_front());
            nseen++;
            if (nseen >= WIN_LEN) begin
                exp_valid = 1'b1;
                exp_cntr  = window_sum();
            end
        end
    endtask

    // One sample, then gap idle cycles (with random data) before the next one.
    task automatic push(input bit d, input int gap);
        bit f;
`ifdef PDM_CLK_GEN_EN
        do step(1'b0, d, f); while (!f);
        if (gap < 0) f = 1'b0;
`else
        step(1'b1, d, f);
        repeat (gap) step(1'b0, 1'($urandom % 2), f);
`endif
    endtask

    // Reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        sample_en = 1'b0;
        #1;
        chk("rst_cntr", cntr, 0);
        chk("rst_valid", cntr_valid, 0);
`ifdef PDM_CLK_GEN_EN
        chk("rst_mic", mic_clk, 0);
`endif
        @(negedge clk);
        hist.delete();
        nseen     = 0;
        exp_cntr  = 0;
        exp_valid = 1'b0;
        k         = 0;
        exp_mic   = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        bit f;
        repeat (2) @(negedge clk);
        chk("init_cntr", cntr, 0);
        chk("init_valid", cntr_valid, 0);
        do_reset();

        // Constant ones, one strobe every 4 clk.
        for (int i = 0; i < 1200; i++) push(1'b1, 3);
        step(1'b0, 1'b0, f);

        // Alternating 1,0 with random spacing.
        do_reset();
        for (int i = 0; i < 1100; i++) push(1'((i + 1) % 2), int'($urandom_range(0, 2)));
        step(1'b0, 1'b0, f);

        // 1000 zeros, then a ramp of ones up to saturation.
        do_reset();
        for (int i = 0; i < 1000; i++) push(1'b0, int'($urandom_range(0, 1)));
        for (int i = 0; i < 1100; i++) push(1'b1, int'($urandom_range(0, 1)));
        step(1'b0, 1'b0, f);

        // Random data with back-to-back bursts, one across the pointer wrap.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int gap;
            gap = ((i >= 995 && i < 1005) || (i % 97) < 10) ? 0 : int'($urandom_range(0, 3));
            push(1'($urandom % 2), gap);
        end
        step(1'b0, 1'b0, f);

        // Fill to a count of 730, then reset in the middle of RUN.
        do_reset();
        for (int i = 0; i < WIN_LEN; i++) push(1'(i < 730), 1);
        step(1'b0, 1'b0, f);
        chk("pre_rst_cntr", cntr, 730);
        do_reset();
        for (int i = 0; i < 1000; i++) push(1'($urandom % 2), int'($urandom_range(0, 2)));
        step(1'b0, 1'b0, f);
        step(1'b0, 1'b0, f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
